// File: rtl/zeroriscy_mp_sram_lat_if.sv
// zeroriscy_mp_sram_lat_if
//   One SRAM access port (request/grant plus response strobe).
//   The memory model instantiates two of these: port 0 for instruction fetch, port 1 for data.
//   Signals:
//     req    request valid               we     1 = write, 0 = read
//     be     write byte enables          addr   byte address, [1:0] ignored
//     wdata  write data                  gnt    request accepted this cycle
//     rvalid one-cycle response strobe   rdata  read data (0 unless rvalid)
//     err    out-of-range flag (0 unless rvalid)
//   Modports: master drives the request, slave (the memory) drives grant and response.
interface zeroriscy_mp_sram_lat_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/zeroriscy_mp_sram_lat.sv
// zeroriscy_mp_sram_lat
//   Dual-port SRAM test model for the zero-riscy bench. Port 0 = instruction side, port 1 = data
//   side; both ports read and write. Each port accepts one request per cycle and answers exactly
//   PN_LATENCY cycles later, in order. Out-of-range accesses are granted but answered with err=1.
//   A port 1 access hitting the same word as a port 0 access in the same cycle (with either one a
//   write) is stalled; port 0 always wins.
//   Optional feature: define ZERORISCY_SRAM_STALL_EN to withhold ~25% of grants per port using a
//   16-bit LFSR per port (taps 16,14,13,11), seeded from STALL_SEED.
//   Ports:
//     clk    clock, all state on posedge
//     rst_n  asynchronous active-low reset (memory contents are not reset)
//     p0     instruction-side port (slave modport)
//     p1     data-side port (slave modport)
module zeroriscy_mp_sram_lat #(
   parameter int unsigned NWORDS     = 65536,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned P0_LATENCY = 1,
   parameter int unsigned P1_LATENCY = 1,
   parameter logic [15:0] STALL_SEED = 16'hACE1
) (
   input logic                    clk,
   input logic                    rst_n,
   zeroriscy_mp_sram_lat_if.slave p0,
   zeroriscy_mp_sram_lat_if.slave p1
);

   localparam int unsigned AW   = $clog2(NWORDS);
   localparam logic [32:0] SPAN = 33'(NWORDS) << 2;

   logic [31:0]   off0, off1;
   logic          in0, in1;
   logic [AW-1:0] idx0, idx1;
   logic          stall0, stall1;
   logic          acc0, acc1, conflict;
   logic [31:0]   rd0, rd1;

   logic [31:0] mem [NWORDS];

   // Offset compare in 33 bits so the top of the window never wraps onto low addresses.
   always_comb begin
      off0 = p0.addr - BASE_ADDR;
      off1 = p1.addr - BASE_ADDR;
      in0  = {1'b0, off0} < SPAN;
      in1  = {1'b0, off1} < SPAN;
      idx0 = off0[AW+1:2];
      idx1 = off1[AW+1:2];
   end

`ifdef ZERORISCY_SRAM_STALL_EN
   logic [15:0] lfsr0_q, lfsr1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr0_q <= STALL_SEED;
         lfsr1_q <= {STALL_SEED[7:0], STALL_SEED[15:8]};
      end else begin
         lfsr0_q <= {lfsr0_q[14:0], lfsr0_q[15] ^ lfsr0_q[13] ^ lfsr0_q[12] ^ lfsr0_q[10]};
         lfsr1_q <= {lfsr1_q[14:0], lfsr1_q[15] ^ lfsr1_q[13] ^ lfsr1_q[12] ^ lfsr1_q[10]};
      end
   end

   assign stall0 = (lfsr0_q[1:0] == 2'b00);
   assign stall1 = (lfsr1_q[1:0] == 2'b00);
`else
   logic unused_seed;
   assign unused_seed = ^STALL_SEED;
   assign stall0      = 1'b0;
   assign stall1      = 1'b0;
`endif

   // Grants are forced low while in reset so nothing is accepted.
   assign acc0     = rst_n & p0.req & ~stall0;
   assign conflict = acc0 & in0 & in1 & (idx0 == idx1) & (p0.we | p1.we);
   assign acc1     = rst_n & p1.req & ~stall1 & ~conflict;
   assign p0.gnt   = acc0;
   assign p1.gnt   = acc1;

   // Read data sampled at the accept edge: the nonblocking write below lands after it.
   assign rd0 = (in0 && !p0.we) ? mem[idx0] : 32'h0;
   assign rd1 = (in1 && !p1.we) ? mem[idx1] : 32'h0;

   // Conflict rule guarantees the two ports never write the same word in one cycle.
   always_ff @(posedge clk) begin
      if (acc0 && in0 && p0.we) begin
         for (int b = 0; b < 4; b++) begin
            if (p0.be[b]) mem[idx0][8*b +: 8] <= p0.wdata[8*b +: 8];
         end
      end
      if (acc1 && in1 && p1.we) begin
         for (int b = 0; b < 4; b++) begin
            if (p1.be[b]) mem[idx1][8*b +: 8] <= p1.wdata[8*b +: 8];
         end
      end
   end

   // Response pipelines; data/err are stored as 0 for empty slots so outputs need no masking.
   logic [P0_LATENCY-1:0] v0_q, e0_q;
   logic [31:0]           d0_q [P0_LATENCY];
   logic [P1_LATENCY-1:0] v1_q, e1_q;
   logic [31:0]           d1_q [P1_LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q <= '0;
         e0_q <= '0;
         for (int i = 0; i < int'(P0_LATENCY); i++) d0_q[i] <= '0;
      end else begin
         v0_q[0] <= acc0;
         e0_q[0] <= acc0 & ~in0;
         d0_q[0] <= acc0 ? rd0 : 32'h0;
         for (int i = 1; i < int'(P0_LATENCY); i++) begin
            v0_q[i] <= v0_q[i-1];
            e0_q[i] <= e0_q[i-1];
            d0_q[i] <= d0_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= '0;
         e1_q <= '0;
         for (int i = 0; i < int'(P1_LATENCY); i++) d1_q[i] <= '0;
      end else begin
         v1_q[0] <= acc1;
         e1_q[0] <= acc1 & ~in1;
         d1_q[0] <= acc1 ? rd1 : 32'h0;
         for (int i = 1; i < int'(P1_LATENCY); i++) begin
            v1_q[i] <= v1_q[i-1];
            e1_q[i] <= e1_q[i-1];
            d1_q[i] <= d1_q[i-1];
         end
      end
   end

   assign p0.rvalid = v0_q[P0_LATENCY-1];
   assign p0.err    = e0_q[P0_LATENCY-1];
   assign p0.rdata  = d0_q[P0_LATENCY-1];
   assign p1.rvalid = v1_q[P1_LATENCY-1];
   assign p1.err    = e1_q[P1_LATENCY-1];
   assign p1.rdata  = d1_q[P1_LATENCY-1];

endmodule
